// File: rtl/alu_cmd_driver.sv
// Command front-end and self-checker for the 8-bit ALU: drives registered operands,
// waits a settle time, samples result/flags against a reference model and reports.
module alu_cmd_driver #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_mismatch,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    input  logic             clr_cnt
);

    localparam int              SCW         = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SCW-1:0]  SETTLE_LOAD = SCW'(SETTLE_CYCLES);
    localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(1);
    localparam logic [SCW-1:0]  SETTLE_ONE  = SCW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [WIDTH-1:0] Y_ZERO     = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Reference model: returns {carry, zero, y}; carry is the borrow for SUB.
    function automatic logic [WIDTH+1:0] ref_model(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       op
    );
        logic [WIDTH:0] ext_s;
        logic           carry_s;
        case (op)
            2'b00: begin
                ext_s   = {1'b0, a} + {1'b0, b};
                carry_s = ext_s[WIDTH];
            end
            2'b01: begin
                ext_s   = {1'b0, a} - {1'b0, b};
                carry_s = (a < b);
            end
            2'b10: begin
                ext_s   = {1'b0, a & b};
                carry_s = 1'b0;
            end
            2'b11: begin
                ext_s   = {1'b0, a | b};
                carry_s = 1'b0;
            end
            default: begin
                ext_s   = {(WIDTH+1){1'b0}};
                carry_s = 1'b0;
            end
        endcase
        return {carry_s, (ext_s[WIDTH-1:0] == Y_ZERO), ext_s[WIDTH-1:0]};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [SCW-1:0]   settle_cnt_r;
    logic             accept_s;
    logic             capture_s;
    logic             release_s;
    logic [WIDTH+1:0] model_s;
    logic             mismatch_s;

    assign cmd_ready  = (state_r == IDLE);
    assign model_s    = ref_model(alu_a, alu_b, alu_opcode);
    assign mismatch_s = (alu_y != model_s[WIDTH-1:0]) ||
                        (alu_zero != model_s[WIDTH]) ||
                        (alu_carryout != model_s[WIDTH+1]);

    // Next-state and handshake strobes
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = SETTLE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    capture_s   = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = SETTLE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    release_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand registers hold the last accepted command so the ALU stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= {WIDTH{1'b0}};
            alu_b      <= {WIDTH{1'b0}};
            alu_opcode <= 2'b00;
        end else if (accept_s) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_opcode <= cmd_op;
        end else begin
            alu_a      <= alu_a;
            alu_b      <= alu_b;
            alu_opcode <= alu_opcode;
        end
    end

    // Settle countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_r <= {SCW{1'b0}};
        end else if (accept_s) begin
            settle_cnt_r <= SETTLE_LOAD;
        end else if ((state_r == SETTLE) && (settle_cnt_r != {SCW{1'b0}})) begin
            settle_cnt_r <= settle_cnt_r - SETTLE_ONE;
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    // Response capture and release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= 1'b0;
            rsp_y        <= {WIDTH{1'b0}};
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_mismatch <= 1'b0;
        end else if (capture_s) begin
            rsp_valid    <= 1'b1;
            rsp_y        <= alu_y;
            rsp_carry    <= alu_carryout;
            rsp_zero     <= alu_zero;
            rsp_mismatch <= mismatch_s;
        end else if (release_s) begin
            rsp_valid    <= 1'b0;
        end else begin
            rsp_valid    <= rsp_valid;
        end
    end

    // Saturating pass/fail counters; a clear overrides a coincident capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= {CNT_W{1'b0}};
            fail_cnt <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            pass_cnt <= {CNT_W{1'b0}};
            fail_cnt <= {CNT_W{1'b0}};
        end else if (capture_s && !mismatch_s && (pass_cnt != CNT_MAX)) begin
            pass_cnt <= pass_cnt + CNT_ONE;
        end else if (capture_s && mismatch_s && (fail_cnt != CNT_MAX)) begin
            fail_cnt <= fail_cnt + CNT_ONE;
        end else begin
            pass_cnt <= pass_cnt;
            fail_cnt <= fail_cnt;
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: one instance with SETTLE_CYCLES=1, one with
// SETTLE_CYCLES=4 and 2-bit counters for latency, saturation and mid-flight reset.
module tb_alu_cmd_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst2_n;

    logic       cmd_valid, cmd_ready, clr_cnt, inject;
    logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, rsp_y;
    logic [1:0] cmd_op, alu_opcode;
    logic       alu_carryout, alu_zero;
    logic       rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_mismatch;
    logic [15:0] pass_cnt, fail_cnt;

    logic       cmd_valid2, cmd_ready2, clr_cnt2;
    logic [7:0] cmd_a2, cmd_b2, alu_a2, alu_b2, alu_y2, rsp_y2;
    logic [1:0] cmd_op2, alu_opcode2;
    logic       alu_carryout2, alu_zero2;
    logic       rsp_valid2, rsp_ready2, rsp_carry2, rsp_zero2, rsp_mismatch2;
    logic [1:0] pass_cnt2, fail_cnt2;

    int checks = 0;
    int failures = 0;

    alu_cmd_driver #(.WIDTH(8), .SETTLE_CYCLES(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_y(alu_y), .alu_carryout(alu_carryout), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_mismatch(rsp_mismatch),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .clr_cnt(clr_cnt)
    );

    alu_cmd_driver #(.WIDTH(8), .SETTLE_CYCLES(4), .CNT_W(2)) u_dut4 (
        .clk(clk), .rst_n(rst2_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_a(cmd_a2), .cmd_b(cmd_b2), .cmd_op(cmd_op2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_opcode(alu_opcode2),
        .alu_y(alu_y2), .alu_carryout(alu_carryout2), .alu_zero(alu_zero2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_y(rsp_y2),
        .rsp_carry(rsp_carry2), .rsp_zero(rsp_zero2), .rsp_mismatch(rsp_mismatch2),
        .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .clr_cnt(clr_cnt2)
    );

    // Behavioural ALU: {carry, zero, y}
    function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
        logic [8:0] t;
        case (op)
            2'b00:   t = {1'b0, a} + {1'b0, b};
            2'b01:   t = {1'b0, a} - {1'b0, b};
            2'b10:   t = {1'b0, a & b};
            default: t = {1'b0, a | b};
        endcase
        return {t[8], (t[7:0] == 8'd0), t[7:0]};
    endfunction

    always_comb begin
        {alu_carryout, alu_zero, alu_y} = alu_fn(alu_a, alu_b, alu_opcode);
        if (inject) alu_y = alu_y ^ 8'h01;
    end

    always_comb begin
        {alu_carryout2, alu_zero2, alu_y2} = alu_fn(alu_a2, alu_b2, alu_opcode2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmd1(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        output int lat);
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic rsp1();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
    endtask

    task automatic cmd2(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        output int lat);
        @(negedge clk);
        cmd_valid2 = 1'b1; cmd_a2 = a; cmd_b2 = b; cmd_op2 = op;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        lat = 0;
        while (!rsp_valid2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic       inj;
        logic [7:0] y;
        logic       c;
        logic       z;
        logic       mis;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        int exp_pass;
        int exp_fail;

        vecs[0] = '{8'd10,  8'd20,  2'b00, 1'b0, 8'd30,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'd200, 8'd100, 2'b00, 1'b0, 8'd44,  1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'd20,  8'd50,  2'b01, 1'b0, 8'd226, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hCC,  8'hAA,  2'b10, 1'b0, 8'h88,  1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'hCC,  8'hAA,  2'b11, 1'b0, 8'hEE,  1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'd50,  8'd50,  2'b01, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'hFF,  8'h01,  2'b00, 1'b0, 8'd0,   1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'd10,  8'd20,  2'b00, 1'b1, 8'd31,  1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; rst2_n = 1'b0;
        cmd_valid = 1'b0; cmd_a = 8'd0; cmd_b = 8'd0; cmd_op = 2'b00;
        rsp_ready = 1'b0; clr_cnt = 1'b0; inject = 1'b0;
        cmd_valid2 = 1'b0; cmd_a2 = 8'd0; cmd_b2 = 8'd0; cmd_op2 = 2'b00;
        rsp_ready2 = 1'b0; clr_cnt2 = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_rsp_y", 32'(rsp_y), 32'd0);
        chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
        rst_n = 1'b1; rst2_n = 1'b1;

        // Table of single commands, SETTLE_CYCLES=1
        exp_pass = 0;
        exp_fail = 0;
        for (int i = 0; i < 8; i++) begin
            inject = vecs[i].inj;
            cmd1(vecs[i].a, vecs[i].b, vecs[i].op, lat);
            chk("latency", 32'(lat), 32'd1);
            chk("alu_a", 32'(alu_a), 32'(vecs[i].a));
            chk("alu_b", 32'(alu_b), 32'(vecs[i].b));
            chk("alu_opcode", 32'(alu_opcode), 32'(vecs[i].op));
            chk("rsp_y", 32'(rsp_y), 32'(vecs[i].y));
            chk("rsp_carry", 32'(rsp_carry), 32'(vecs[i].c));
            chk("rsp_zero", 32'(rsp_zero), 32'(vecs[i].z));
            chk("rsp_mismatch", 32'(rsp_mismatch), 32'(vecs[i].mis));
            if (vecs[i].mis) exp_fail++;
            else exp_pass++;
            chk("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
            chk("fail_cnt", 32'(fail_cnt), 32'(exp_fail));
            rsp1();
            inject = 1'b0;
        end

        // Counter clear
        @(negedge clk); clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        chk("clr_pass", 32'(pass_cnt), 32'd0);
        chk("clr_fail", 32'(fail_cnt), 32'd0);

        // Clear coinciding with capture: clear wins
        @(negedge clk); cmd_valid = 1'b1; cmd_a = 8'd1; cmd_b = 8'd2; cmd_op = 2'b00;
        @(negedge clk); cmd_valid = 1'b0; clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        chk("clrcap_valid", 32'(rsp_valid), 32'd1);
        chk("clrcap_y", 32'(rsp_y), 32'd3);
        chk("clrcap_pass", 32'(pass_cnt), 32'd0);
        rsp1();

        // Backpressure with a competing command held on the input
        cmd1(8'd3, 8'd4, 2'b00, lat);
        chk("bp_latency", 32'(lat), 32'd1);
        cmd_valid = 1'b1; cmd_a = 8'd99; cmd_b = 8'd1; cmd_op = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_y", 32'(rsp_y), 32'd7);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_alu_a", 32'(alu_a), 32'd3);
            chk("bp_alu_op", 32'(alu_opcode), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_ready", 32'(cmd_ready), 32'd1);
        chk("bp_no_same_cycle", 32'(alu_a), 32'd3);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_next_alu_a", 32'(alu_a), 32'd99);
        chk("bp_next_op", 32'(alu_opcode), 32'd1);
        chk("bp_next_busy", 32'(cmd_ready), 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp2_latency", 32'(lat), 32'd1);
        chk("bp2_rsp_y", 32'(rsp_y), 32'd98);
        chk("bp2_carry", 32'(rsp_carry), 32'd0);
        chk("bp2_pass", 32'(pass_cnt), 32'd2);
        rsp1();

        // SETTLE_CYCLES=4: latency and 2-bit counter saturation
        for (int k = 0; k < 4; k++) begin
            cmd2(8'(k + 1), 8'd1, 2'b00, lat);
            chk("s4_latency", 32'(lat), 32'd4);
            chk("s4_rsp_y", 32'(rsp_y2), 32'(k + 2));
            chk("s4_mismatch", 32'(rsp_mismatch2), 32'd0);
            chk("s4_pass_sat", 32'(pass_cnt2), (k < 3) ? 32'(k + 1) : 32'd3);
            rsp_ready2 = 1'b1;
            @(negedge clk);
            rsp_ready2 = 1'b0;
            chk("s4_drop", 32'(rsp_valid2), 32'd0);
        end

        // Reset in the middle of SETTLE
        @(negedge clk); cmd_valid2 = 1'b1; cmd_a2 = 8'h55; cmd_b2 = 8'h0F; cmd_op2 = 2'b10;
        @(negedge clk); cmd_valid2 = 1'b0;
        chk("mid_alu_a", 32'(alu_a2), 32'h55);
        chk("mid_busy", 32'(cmd_ready2), 32'd0);
        @(negedge clk);
        rst2_n = 1'b0;
        #1;
        chk("mid_rst_alu_a", 32'(alu_a2), 32'd0);
        chk("mid_rst_alu_b", 32'(alu_b2), 32'd0);
        chk("mid_rst_alu_op", 32'(alu_opcode2), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid2), 32'd0);
        chk("mid_rst_pass", 32'(pass_cnt2), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready2), 32'd1);
        @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("mid_no_rsp", 32'(rsp_valid2), 32'd0);
        end
        chk("mid_cnt_pass", 32'(pass_cnt2), 32'd0);
        chk("mid_cnt_fail", 32'(fail_cnt2), 32'd0);
        chk("mid_idle", 32'(cmd_ready2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
